// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run/debug sequencer: state encoding,
// stop-cause codes and register index width.
package cpu_dbg_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] STOP_STEP    = 2'd0;
  localparam logic [1:0] STOP_BP      = 2'd1;
  localparam logic [1:0] STOP_TIMEOUT = 2'd2;
  localparam logic [1:0] STOP_HALT    = 2'd3;

endpackage

// File: rtl/reg_dump_seq.sv
// Register dump sequencer: walks an index over the register file and
// presents one beat per index on a valid/ready port while active.
module reg_dump_seq
  import cpu_dbg_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 active,
  input  logic                 ready,
  output logic                 valid,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 last
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  logic fire;

  assign valid = active;
  assign fire  = active && ready;
  assign last  = fire && (idx == LAST_IDX);

  // Index only advances on an accepted beat, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (go || last) begin
      idx <= '0;
    end else if (fire) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for sccomp: gates the CPU enable for free run or
// single step, stops on breakpoint/budget/halt, then dumps the register file.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int MAX_CYCLES = 1000,
  parameter int NUM_REGS   = 32,
  parameter int PC_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic                 bp_en,
  input  logic [PC_W-1:0]      bp_pc,
  input  logic [PC_W-1:0]      pc,
  output logic                 cpu_en,
  output logic [REG_IDX_W-1:0] reg_sel,
  input  logic [31:0]          reg_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [31:0]          dump_data,
  output logic [31:0]          cycle_cnt,
  output logic [1:0]           stop_cause,
  output logic                 done
);

  state_t               state, next_state;
  logic                 armed;
  logic                 launch, bp_hit, timeout, stop_now;
  logic                 dump_go, dump_last;
  logic [1:0]           cause;
  logic [REG_IDX_W-1:0] idx;

  // Breakpoint needs armed so a resume executes the instruction it stopped on.
  assign bp_hit   = armed && bp_en && (pc == bp_pc);
  assign timeout  = (cycle_cnt == 32'(MAX_CYCLES));
  assign stop_now = bp_hit || timeout || halt_req;
  assign cause    = bp_hit ? STOP_BP : (timeout ? STOP_TIMEOUT : STOP_HALT);
  assign launch   = ((state == ST_IDLE) || (state == ST_DONE)) && (start || step);
  assign dump_go  = ((state == ST_RUN) && stop_now) || (state == ST_STEP);

  always_comb begin
    next_state = state;
    cpu_en     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = ST_RUN;
        else if (step) next_state = ST_STEP;
      end
      ST_RUN: begin
        cpu_en = !stop_now;
        if (stop_now) next_state = ST_DUMP;
      end
      ST_STEP: begin
        cpu_en     = 1'b1;
        next_state = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_last) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cycle_cnt  <= '0;
      stop_cause <= STOP_STEP;
      armed      <= 1'b0;
    end else begin
      state <= next_state;
      if (launch) begin
        cycle_cnt <= '0;
        armed     <= 1'b0;
      end else begin
        if (cpu_en && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
        if (state == ST_RUN) armed <= 1'b1;
      end
      if ((state == ST_RUN) && stop_now) stop_cause <= cause;
      else if (state == ST_STEP) stop_cause <= STOP_STEP;
    end
  end

  reg_dump_seq #(
    .NUM_REGS(NUM_REGS)
  ) u_dump (
    .clk   (clk),
    .rst   (rst),
    .go    (dump_go),
    .active(state == ST_DUMP),
    .ready (dump_ready),
    .valid (dump_valid),
    .idx   (idx),
    .last  (dump_last)
  );

  assign reg_sel   = (state == ST_DUMP) ? idx : '0;
  assign dump_idx  = idx;
  assign dump_data = reg_data;
  assign done      = (state == ST_DONE);

endmodule
